// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the IF stage (master) and imem (slave).
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the PC, issues in-order imem fetches and queues responses for ID.
// Optional macro IF_PERF_CNT_EN adds delivered/discarded instruction counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master imem,
  input  logic          redirect_en_i,
  input  logic [31:0]   redirect_addr_i,
  output logic          if_id_valid_o,
  input  logic          id_ready_i,
  output logic [31:0]   if_id_pc_o,
  output logic [31:0]   if_id_pc_next_o,
  output logic [31:0]   if_id_instr_o,
  output logic [31:0]   perf_fetched_o,
  output logic [31:0]   perf_dropped_o
);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic          req_fire;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // In-flight requests plus queued entries never exceed DEPTH, so a push always has room.
  always_comb begin
    redirect_tgt   = {redirect_addr_i[31:2], 2'b00};
    imem.req_valid = !rst_i && !redirect_en_i &&
                     (({1'b0, outstanding} + {1'b0, count}) < CAP);
    imem.req_addr  = fetch_pc;
    req_fire       = imem.req_valid && imem.req_ready;
    push           = imem.rsp_valid && !redirect_en_i && (drop_cnt == '0);
    pop            = if_id_valid_o && id_ready_i && !redirect_en_i;
  end

  assign if_id_valid_o   = (count != '0);
  assign if_id_pc_o      = pc_q[head];
  assign if_id_pc_next_o = pc_q[head] + 32'd4;
  assign if_id_instr_o   = instr_q[head];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem.rsp_valid);
      if (redirect_en_i) begin
        // Everything still in flight, minus a response landing now, belongs to the old path.
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        drop_cnt <= outstanding - CW'(imem.rsp_valid);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem.rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            pc_q[tail]    <= rsp_pc;
            instr_q[tail] <= imem.rsp_data;
            tail          <= ptr_inc(tail);
            rsp_pc        <= rsp_pc + 32'd4;
          end
        end
        if (pop) head <= ptr_inc(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] dropped_cnt;
  logic        rsp_drop;

  assign rsp_drop = imem.rsp_valid && (redirect_en_i || (drop_cnt != '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetched_cnt <= '0;
      dropped_cnt <= '0;
    end else begin
      if (pop) fetched_cnt <= fetched_cnt + 32'd1;
      dropped_cnt <= dropped_cnt + 32'(rsp_drop) + (redirect_en_i ? 32'(count) : 32'd0);
    end
  end

  assign perf_fetched_o = fetched_cnt;
  assign perf_dropped_o = dropped_cnt;
`else
  assign perf_fetched_o = '0;
  assign perf_dropped_o = '0;
`endif

  rsp_needs_request: assert property (
    @(posedge clk_i) disable iff (rst_i) imem.rsp_valid |-> (outstanding != '0)
  );
endmodule
